screen_mem_arbiter: RTL
=======================

Name: screen_mem_arbiter

Overview:
- Responder side of the renderer's screen-read port (vid_read_en / vid_read_addr / vid_read_data).
- Owns the single-port 2 KiB work RAM that is shared with the 6502 core.
- When the renderer asks for RAM, the block waits for an instruction boundary (cpu_sync), stalls the CPU via cpu_rdy, serves video reads for the rest of the active line, then hands the RAM back.
- Sits between cpu core, generic_ram instance and vga_render.

Parameters:
- ADDR_W, 11, RAM address width (2 KiB).
- DRAIN_MAX, 8, max cycles to wait for cpu_sync before a forced grant.
- MISS_W, 8, width of the saturating miss counter.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high
- cpu_addr  in  16  CPU address
- cpu_we  in  1  CPU write strobe
- cpu_din  in  8  CPU write data
- cpu_sync  in  1  high on opcode-fetch cycle
- cpu_dout  out  8  CPU read data (held stable while stalled)
- cpu_rdy  out  1  CPU ready; low = stall
- vid_read_en  in  1  renderer request, level
- vid_read_addr  in  ADDR_W  renderer read address
- vid_read_data  out  8  pixel byte, 1-cycle latency
- mem_addr  out  ADDR_W  to RAM
- mem_we  out  1  to RAM
- mem_din  out  8  to RAM
- mem_dout  in  8  from RAM, registered read (1-cycle latency)
- vid_granted  out  1  state==VID_OWN
- miss_cnt  out  MISS_W  saturating count of request-not-served cycles

Behaviour:
- Reset (clk, synchronous active-high): state=CPU_OWN, cpu_rdy=1, vid_granted=0, miss_cnt=0, drain counter=0, vid_valid=0, cpu_dout hold=0.
- States and transitions:
  - CPU_OWN:
    - vid_read_en=1 and cpu_sync=1 -> VID_OWN.
    - vid_read_en=1 and cpu_sync=0 -> DRAIN (drain counter cleared).
  - DRAIN: CPU still owns RAM.
    - vid_read_en=0 -> CPU_OWN (no stall).
    - Otherwise, cpu_sync=1 -> VID_OWN.
    - Otherwise, drain counter==DRAIN_MAX-1 and cpu_we=0 -> VID_OWN (forced).
    - Writes are never interrupted: a forced grant waits for cpu_we=0.
  - VID_OWN: vid_read_en=0 -> HANDBACK.
  - HANDBACK: lasts exactly 1 cycle, then -> CPU_OWN. During it, mem_addr=cpu_addr so the RAM output is valid for the CPU's repeated access.
- cpu_rdy (registered): 1 when the next state is CPU_OWN or DRAIN, 0 when it is VID_OWN or HANDBACK. The CPU access in the cycle that leaves DRAIN completes normally.
- mem_addr: vid_read_addr in VID_OWN, otherwise cpu_addr[ADDR_W-1:0].
- mem_we: cpu_we & cpu_rdy & (cpu_addr[15:ADDR_W]==0). Out-of-range writes are dropped. mem_we is never 1 in VID_OWN or HANDBACK.
- mem_din: cpu_din.
- vid_valid = registered (state==VID_OWN).
- vid_read_data: mem_dout when vid_valid=1, else 8'h00 (renders palette entry 0).
- cpu_dout: mem_dout when the previous cycle was CPU-owned, else the held value. The held register updates only on CPU-owned data cycles.
- miss_cnt: +1 every cycle with vid_read_en=1 and state!=VID_OWN. Saturates at all-ones. Cleared only by reset.
- Simultaneous events:
  - Request rise together with cpu_sync -> direct grant, zero DRAIN cycles.
  - Request fall in the same cycle as the grant condition -> the fall wins; stay or return to CPU_OWN.
- Reset mid-VID_OWN: the next cycle is CPU_OWN with cpu_rdy=1. vid_read_data is 0 from the cycle after reset.

Decomposition:
- Shared package holds:
  - state encoding: CPU_OWN=2'd0, DRAIN=2'd1, VID_OWN=2'd2, HANDBACK=2'd3.
  - constants SCREEN_BASE=11'h200 and RAM_BYTES=2048.
- One sub-module is natural: arb_sat_counter, the generic saturating counter used for the drain count and miss_cnt.

Test Plan:
- Reset, then idle with the CPU writing 8'h5A to 16'h0203 -> mem_we=1, mem_addr=11'h203; a read-back returns 8'h5A on cpu_dout one cycle later; cpu_rdy=1 throughout.
- vid_read_en rises with cpu_sync=0, cpu_sync arrives 3 cycles later:
  - state goes DRAIN for 3 cycles, then VID_OWN; cpu_rdy=0 from the next cycle.
  - miss_cnt=4.
  - vid_read_addr=11'h200 with RAM[0x200]=8'h07 -> vid_read_data=8'h07 one cycle later.
- vid_read_en held with cpu_sync never asserted and cpu_we=0 -> forced grant after 8 DRAIN cycles; miss_cnt=9.
- Forced-grant deadline reached while cpu_we=1 -> grant is delayed until the first cycle with cpu_we=0; mem_we is never 1 in VID_OWN.
- vid_read_en falls in VID_OWN:
  - exactly 1 HANDBACK cycle, with mem_addr=cpu_addr and cpu_rdy=0.
  - then CPU_OWN with cpu_rdy=1; vid_read_data=8'h00 from the cycle after vid_valid drops.
  - the stalled CPU read of 16'h0010 returns the correct byte.
- Reset asserted mid-VID_OWN -> next cycle CPU_OWN, cpu_rdy=1, vid_granted=0, miss_cnt=0. Separately, drive 300 unserved request cycles -> miss_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/screen_mem_arbiter_pkg.sv
// Shared definitions for the screen-memory arbiter: ownership states and
// the work-RAM map seen by the renderer.
package screen_mem_arbiter_pkg;

   // Ownership state encoding (legacy-compatible 2-bit constants).
   localparam logic [1:0] CPU_OWN  = 2'd0;
   localparam logic [1:0] DRAIN    = 2'd1;
   localparam logic [1:0] VID_OWN  = 2'd2;
   localparam logic [1:0] HANDBACK = 2'd3;

   // Work-RAM map: the screen buffer starts at 0x200 inside the 2 KiB RAM.
   localparam logic [10:0] SCREEN_BASE = 11'h200;
   localparam int          RAM_BYTES   = 2048;

   // True in the states where the CPU is stalled off the RAM.
   function automatic logic is_stall_state(input logic [1:0] st);
      return (st == VID_OWN) || (st == HANDBACK);
   endfunction

endpackage

// File: rtl/screen_mem_arbiter_sat.sv
// Generic saturating up-counter with synchronous clear; used for the
// drain-wait count and the video miss counter.
module arb_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (v == {W{1'b1}}) ? v : v + {{(W-1){1'b0}}, 1'b1};
   endfunction

   // Clear has priority over increment; reset behaves like a clear.
   always_ff @(posedge clk) begin
      if (reset || clr)
         count <= '0;
      else if (inc)
         count <= sat_inc(count);
   end

endmodule

// File: rtl/screen_mem_arbiter.sv
// Arbitrates the single-port work RAM between the 6502 core and the video
// renderer. Video requests wait for an instruction boundary (or a bounded
// drain timeout that never cuts a write), stall the CPU via cpu_rdy, serve
// pixel reads, then hand the RAM back through a one-cycle HANDBACK state that
// re-presents the CPU address so its stalled read completes correctly.
module screen_mem_arbiter
   import screen_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W    = 11,
   parameter int DRAIN_MAX = 8,
   parameter int MISS_W    = 8,
   parameter int DATA_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       cpu_addr,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_din,
   input  logic              cpu_sync,
   output logic [DATA_W-1:0] cpu_dout,
   output logic              cpu_rdy,
   input  logic              vid_read_en,
   input  logic [ADDR_W-1:0] vid_read_addr,
   output logic [DATA_W-1:0] vid_read_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              vid_granted,
   output logic [MISS_W-1:0] miss_cnt
);

   localparam int DRAIN_W = (DRAIN_MAX > 2) ? $clog2(DRAIN_MAX) : 2;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);

   logic [1:0]         state;
   logic [1:0]         next_state;
   logic [DRAIN_W-1:0] drain_cnt;
   logic               drain_done;
   logic               cpu_in_range;
   logic               vid_vld_p1;
   logic               cpu_vld_p1;
   logic [DATA_W-1:0]  cpu_hold_p1;

   assign drain_done   = (drain_cnt == DRAIN_LAST);
   assign cpu_in_range = (cpu_addr[15:ADDR_W] == '0);

   // Drain counter: counts cycles spent in DRAIN, parks at the deadline so a
   // long CPU write burst still sees the timeout once it ends.
   arb_sat_counter #(.W(DRAIN_W)) u_drain_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (state != DRAIN),
      .inc   ((state == DRAIN) && !drain_done),
      .count (drain_cnt)
   );

   // Miss counter: every cycle the renderer asks but does not own the RAM.
   arb_sat_counter #(.W(MISS_W)) u_miss_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (vid_read_en && (state != VID_OWN)),
      .count (miss_cnt)
   );

   // Ownership next-state: a dropped request always wins over a grant.
   always_comb begin
      next_state = state;
      case (state)
         CPU_OWN: begin
            if (vid_read_en)
               next_state = cpu_sync ? VID_OWN : DRAIN;
         end
         DRAIN: begin
            if (!vid_read_en)
               next_state = CPU_OWN;
            else if (cpu_sync)
               next_state = VID_OWN;
            else if (drain_done && !cpu_we)
               next_state = VID_OWN;
         end
         VID_OWN: begin
            if (!vid_read_en)
               next_state = HANDBACK;
         end
         default: next_state = CPU_OWN;
      endcase
   end

   // State and registered ready: ready reflects where we are heading so the
   // CPU access in the cycle that leaves DRAIN still completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CPU_OWN;
         cpu_rdy <= 1'b1;
      end else begin
         state   <= next_state;
         cpu_rdy <= !is_stall_state(next_state);
      end
   end

   // RAM has one cycle of read latency: remember who owned the address cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         vid_vld_p1 <= 1'b0;
         cpu_vld_p1 <= 1'b0;
      end else begin
         vid_vld_p1 <= (state == VID_OWN);
         cpu_vld_p1 <= (state != VID_OWN);
      end
   end

   // CPU read-data hold: keeps the last CPU byte stable while stalled.
   always_ff @(posedge clk) begin
      if (reset)
         cpu_hold_p1 <= '0;
      else if (cpu_vld_p1)
         cpu_hold_p1 <= mem_dout;
   end

   assign mem_addr      = (state == VID_OWN) ? vid_read_addr : cpu_addr[ADDR_W-1:0];
   assign mem_we        = cpu_we && cpu_rdy && cpu_in_range && !is_stall_state(state);
   assign mem_din       = cpu_din;
   assign vid_granted   = (state == VID_OWN);
   assign vid_read_data = vid_vld_p1 ? mem_dout : '0;
   assign cpu_dout      = cpu_vld_p1 ? mem_dout : cpu_hold_p1;

endmodule
